// File: rtl/rca_32_serial_feeder.sv
// Serial byte feeder for a 32-bit ripple-carry adder: assembles A, B and cin from a
// byte stream, waits a settle window, then captures and presents the adder result.
module rca_32_serial_feeder #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [64:0] add_x,
    input  logic [32:0] add_y,
    output logic [31:0] out_sum,
    output logic        out_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] op_count
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        OUT    = 2'd2
    } state_t;

    state_t           state;
    logic [3:0]       byte_idx;
    logic [CNT_W-1:0] settle_cnt;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic             cin;

    // Interleave operand registers into the adder's bit-serial operand vector
    always_comb begin
        add_x    = '0;
        add_x[0] = cin;
        for (int i = 0; i < 32; i++) begin
            add_x[2*i+1] = op_a[i];
            add_x[2*i+2] = op_b[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            byte_idx   <= '0;
            settle_cnt <= '0;
            op_a       <= '0;
            op_b       <= '0;
            cin        <= 1'b0;
            in_ready   <= 1'b1;
            out_sum    <= '0;
            out_cout   <= 1'b0;
            out_valid  <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid && in_ready) begin
                        if (byte_idx < 4'd4) begin
                            op_a[{byte_idx[1:0], 3'b000} +: 8] <= in_data;
                            byte_idx <= byte_idx + 4'd1;
                        end else if (byte_idx < 4'd8) begin
                            op_b[{byte_idx[1:0], 3'b000} +: 8] <= in_data;
                            byte_idx <= byte_idx + 4'd1;
                        end else begin
                            cin        <= in_data[0];
                            byte_idx   <= '0;
                            settle_cnt <= CNT_W'(SETTLE_CYCLES);
                            in_ready   <= 1'b0;
                            state      <= SETTLE;
                        end
                    end
                end
                // Counter runs SETTLE_CYCLES down to zero, so the result is captured
                // SETTLE_CYCLES+1 edges after the final operand bit lands in add_x
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        out_sum   <= add_y[31:0];
                        out_cout  <= add_y[32];
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                OUT: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        in_ready  <= 1'b1;
                        state     <= LOAD;
                    end
                end
                default: begin
                    state    <= LOAD;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rca_32_serial_feeder.sv
// Directed bench for rca_32_serial_feeder with a behavioural 32-bit adder on add_x/add_y.
module tb_rca_32_serial_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [64:0] add_x;
    logic [32:0] add_y;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] op_count;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_ops = 16'd0;

    rca_32_serial_feeder #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .add_x(add_x), .add_y(add_y), .out_sum(out_sum), .out_cout(out_cout),
        .out_valid(out_valid), .out_ready(out_ready), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Downstream ripple-carry adder model
    logic [31:0] ma, mb;
    always_comb begin
        ma = '0;
        mb = '0;
        for (int i = 0; i < 32; i++) begin
            ma[i] = add_x[2*i+1];
            mb[i] = add_x[2*i+2];
        end
        add_y = {1'b0, ma} + {1'b0, mb} + 33'(add_x[0]);
    end

    function automatic logic [64:0] pack_x(input logic [31:0] a, input logic [31:0] b, input logic c);
        logic [64:0] x;
        x = '0;
        x[0] = c;
        for (int i = 0; i < 32; i++) begin
            x[2*i+1] = a[i];
            x[2*i+2] = b[i];
        end
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL send_byte: in_ready timeout, got %b required 1", in_ready);
        end
        in_data  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic [7:0] c);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(b[8*i +: 8]);
        send_byte(c);
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (out_valid !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_valid: out_valid got %b required 1 within 40 cycles", out_valid);
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_ops = exp_ops + 16'd1;
    endtask

    task automatic check_result(input string name, input logic [31:0] es, input logic ec);
        vectors++;
        if (out_sum !== es) begin
            miscompares++;
            $display("FAIL %s sum: got %h required %h", name, out_sum, es);
        end
        vectors++;
        if (out_cout !== ec) begin
            miscompares++;
            $display("FAIL %s cout: got %b required %b", name, out_cout, ec);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset in_ready: got %b required 1", in_ready); end
        vectors++;
        if (add_x !== 65'd0) begin miscompares++; $display("FAIL reset add_x: got %h required 0", add_x); end
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset out_valid: got %b required 0", out_valid); end
        vectors++;
        if (op_count !== 16'd0) begin miscompares++; $display("FAIL reset op_count: got %h required 0", op_count); end
        check_result("reset", 32'd0, 1'b0);
    endtask

    task automatic test_carry_out();
        int e;
        send_op(32'hFFFF_FFFF, 32'h0000_0001, 8'h00);
        wait_valid(e);
        check_result("carry_out", 32'h0000_0000, 1'b1);
        handshake();
        vectors++;
        if (op_count !== exp_ops) begin miscompares++; $display("FAIL carry_out op_count: got %h required %h", op_count, exp_ops); end
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL carry_out release: in_ready %b out_valid %b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_latency();
        int e;
        send_op(32'h1234_5678, 32'h9ABC_DEF0, 8'h01);
        vectors++;
        if (add_x !== pack_x(32'h1234_5678, 32'h9ABC_DEF0, 1'b1)) begin
            miscompares++;
            $display("FAIL latency add_x: got %h required %h", add_x, pack_x(32'h1234_5678, 32'h9ABC_DEF0, 1'b1));
        end
        wait_valid(e);
        vectors++;
        if (e !== 3) begin miscompares++; $display("FAIL latency edges: got %0d required 3", e); end
        check_result("latency", 32'hACF1_3569, 1'b0);
        handshake();
    endtask

    task automatic test_cin_mask();
        int e;
        send_op(32'd0, 32'd0, 8'hFF);
        wait_valid(e);
        check_result("cin_ff", 32'h0000_0001, 1'b0);
        handshake();
        send_op(32'd0, 32'd0, 8'hFE);
        wait_valid(e);
        check_result("cin_fe", 32'h0000_0000, 1'b0);
        handshake();
    endtask

    task automatic test_backpressure();
        int e;
        send_op(32'h0000_0001, 32'h0000_0002, 8'h00);
        wait_valid(e);
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL backpressure hold %0d: out_valid %b in_ready %b required 1 0", i, out_valid, in_ready);
            end
            check_result("backpressure_hold", 32'h0000_0003, 1'b0);
        end
        vectors++;
        if (add_x !== pack_x(32'h1, 32'h2, 1'b0)) begin
            miscompares++;
            $display("FAIL backpressure operands: got %h required %h", add_x, pack_x(32'h1, 32'h2, 1'b0));
        end
        in_valid = 1'b0;
        handshake();
        vectors++;
        if (op_count !== exp_ops || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL backpressure release: op_count %h in_ready %b out_valid %b required %h 1 0",
                     op_count, in_ready, out_valid, exp_ops);
        end
        check_result("backpressure_retain", 32'h0000_0003, 1'b0);
    endtask

    task automatic test_reset_abort();
        int e;
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h77;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        exp_ops = 16'd0;
        vectors++;
        if (add_x !== 65'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_abort: add_x %h in_ready %b required 0 1", add_x, in_ready);
        end
        send_op(32'd3, 32'd4, 8'h00);
        wait_valid(e);
        check_result("reset_abort_sum", 32'd7, 1'b0);
        handshake();
        vectors++;
        if (op_count !== exp_ops) begin miscompares++; $display("FAIL reset_abort op_count: got %h required %h", op_count, exp_ops); end
    endtask

    task automatic test_back_to_back();
        int e;
        logic [31:0] a;
        // Stand in for 65533 earlier handshakes, which would take far too long to replay
        dut.op_count = 16'hFFFD;
        exp_ops = 16'hFFFD;
        for (int k = 0; k < 3; k++) begin
            a = 32'h1000_0000 * 32'(k + 1);
            send_op(a, 32'h0000_00FF, 8'h01);
            wait_valid(e);
            check_result("back_to_back", a + 32'h100, 1'b0);
            handshake();
            vectors++;
            if (op_count !== exp_ops) begin
                miscompares++;
                $display("FAIL back_to_back op_count %0d: got %h required %h", k, op_count, exp_ops);
            end
        end
        vectors++;
        if (op_count !== 16'h0000) begin miscompares++; $display("FAIL op_count wrap: got %h required 0000", op_count); end
    endtask

    initial begin
        rst = 1'b1;
        in_data = 8'h00;
        in_valid = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_carry_out();
        test_latency();
        test_cin_mask();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
